// File: rtl/riscv_pkg.sv
// Shared core types: arbiter FSM state, port ownership and the default data width.
package riscv_pkg;

    localparam int unsigned RV_XLEN = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_e;

    // On contention the port that did not own the bus last time wins.
    function automatic arb_owner_e pickOwner(
        input logic       ifReq,
        input logic       dmReq,
        input arb_owner_e lastOwner
    );
        arb_owner_e sel;
        sel = OWN_IF;
        if (ifReq && dmReq) begin
            sel = (lastOwner == OWN_IF) ? OWN_DM : OWN_IF;
        end else if (dmReq) begin
            sel = OWN_DM;
        end
        return sel;
    endfunction

endpackage

// File: rtl/bus_arbiter.sv
// Two-port (fetch/data) round-robin arbiter onto a single memory port,
// one transaction outstanding, with response timeout and contention counter.
module bus_arbiter
    import riscv_pkg::*;
#(
    parameter int XLEN           = RV_XLEN,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,

    input  logic            if_req_i,
    input  logic [XLEN-1:0] if_addr_i,
    output logic            if_gnt_o,
    output logic            if_rvalid_o,
    output logic            if_err_o,

    input  logic            dm_req_i,
    input  logic [XLEN-1:0] dm_addr_i,
    input  logic            dm_we_i,
    input  logic [XLEN-1:0] dm_wdata_i,
    input  logic [3:0]      dm_be_i,
    output logic            dm_gnt_o,
    output logic            dm_rvalid_o,
    output logic            dm_err_o,

    output logic [XLEN-1:0] rdata_o,

    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic [3:0]      mem_be_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,

    output logic            busy_o,
    output logic [15:0]     conflict_cnt_o
);

    // Handshake: a requester holds *_req_i and its fields until its *_gnt_o
    // pulse; memory accepts with mem_gnt_i while mem_req_o is high, and
    // answers later with a one-cycle mem_rvalid_i, which is only honoured in RSP.

    localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT_CYCLES);

    arb_state_e      state;
    arb_state_e      stateNext;
    arb_owner_e      owner;
    arb_owner_e      selOwner;
    logic [XLEN-1:0] addrQ;
    logic [XLEN-1:0] wdataQ;
    logic            weQ;
    logic [3:0]      beQ;
    logic [15:0]     toCnt;
    logic [15:0]     conflictCnt;

    logic anyReq;
    logic memAccept;
    logic rspHit;
    logic timedOut;
    logic rspDone;
    logic conflictHit;
    logic outEn;

    assign anyReq    = if_req_i | dm_req_i;
    assign selOwner  = pickOwner(if_req_i, dm_req_i, owner);
    assign memAccept = (state == REQ) && mem_gnt_i;
    assign rspHit    = (state == RSP) && mem_rvalid_i;
    // A response arriving on the timeout cycle wins over the error completion.
    assign timedOut  = (state == RSP) && !mem_rvalid_i && (toCnt == TIMEOUT_VAL);
    assign rspDone   = rspHit | timedOut;

    always_comb begin
        conflictHit = 1'b0;
        if (state == IDLE) begin
            conflictHit = if_req_i & dm_req_i;
        end else begin
            conflictHit = (if_req_i && owner != OWN_IF) ||
                          (dm_req_i && owner != OWN_DM);
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (anyReq)    stateNext = REQ;
            REQ:     if (mem_gnt_i) stateNext = RSP;
            RSP:     if (rspDone)   stateNext = IDLE;
            default:                stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            owner       <= OWN_IF;
            addrQ       <= '0;
            wdataQ      <= '0;
            weQ         <= 1'b0;
            beQ         <= 4'h0;
            toCnt       <= 16'h0;
            conflictCnt <= 16'h0;
        end else begin
            state <= stateNext;

            // owner doubles as the last-owner memory for round-robin.
            if (state == IDLE && anyReq) begin
                owner <= selOwner;
                if (selOwner == OWN_DM) begin
                    addrQ  <= dm_addr_i;
                    wdataQ <= dm_wdata_i;
                    weQ    <= dm_we_i;
                    beQ    <= dm_be_i;
                end else begin
                    addrQ  <= if_addr_i;
                    wdataQ <= '0;
                    weQ    <= 1'b0;
                    beQ    <= 4'hF;
                end
            end

            if (memAccept) begin
                toCnt <= 16'h0;
            end else if (state == RSP) begin
                toCnt <= toCnt + 16'h1;
            end

            if (conflictHit && conflictCnt != 16'hFFFF) begin
                conflictCnt <= conflictCnt + 16'h1;
            end
        end
    end

    // Responder-side strobes are masked during reset so an abandoned
    // transaction never reaches its requester.
    assign outEn = !rst_i;

    assign if_gnt_o    = outEn && memAccept && (owner == OWN_IF);
    assign dm_gnt_o    = outEn && memAccept && (owner == OWN_DM);
    assign if_rvalid_o = outEn && rspDone   && (owner == OWN_IF);
    assign dm_rvalid_o = outEn && rspDone   && (owner == OWN_DM);
    assign if_err_o    = outEn && timedOut  && (owner == OWN_IF);
    assign dm_err_o    = outEn && timedOut  && (owner == OWN_DM);
    assign rdata_o     = (outEn && rspHit) ? mem_rdata_i : '0;

    assign mem_req_o   = (state == REQ);
    assign mem_we_o    = weQ;
    assign mem_addr_o  = addrQ;
    assign mem_wdata_o = wdataQ;
    assign mem_be_o    = beQ;

    assign busy_o         = (state != IDLE);
    assign conflict_cnt_o = conflictCnt;

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter XLEN, default 32 (riscv_pkg), sets address/data width.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, sets the number of RSP cycles before an error completion; legal range 1..65535.
REQ-003 clk_i  in  1  single clock, all state updates on rising edge.
REQ-004 rst_i  in  1  synchronous reset, active-high.
REQ-005 if_req_i / dm_req_i  in  1  fetch / data requester asserts a request.
REQ-006 if_addr_i / dm_addr_i  in  XLEN  request address.
REQ-007 dm_we_i  in  1, dm_wdata_i  in  XLEN, dm_be_i  in  4  data-port write enable, write data and byte enables; the fetch port is read-only.
REQ-008 if_gnt_o / dm_gnt_o  out  1  one-cycle pulse: the request was accepted by memory.
REQ-009 if_rvalid_o / dm_rvalid_o  out  1, if_err_o / dm_err_o  out  1, rdata_o  out  XLEN  response strobe, error flag and shared read data.
REQ-010 mem_req_o  out  1, mem_we_o  out  1, mem_addr_o  out  XLEN, mem_wdata_o  out  XLEN, mem_be_o  out  4  shared memory port.
REQ-011 mem_gnt_i  in  1, mem_rvalid_i  in  1, mem_rdata_i  in  XLEN  memory acceptance, response strobe and read data.
REQ-012 busy_o  out  1, conflict_cnt_o  out  16  transaction-in-flight flag and contention counter.

Function
REQ-013 The FSM SHALL have the states IDLE, REQ and RSP, with one transaction outstanding at most.
REQ-014 In IDLE with exactly one *_req_i high, that requester SHALL become owner; its addr/we/wdata/be SHALL be registered (fetch: we=0, be=4'hF); next state REQ.
REQ-015 In IDLE with both requests high, the owner SHALL be the requester that was not the last owner (round-robin); the last-owner register resets to fetch, so data wins the first conflict.
REQ-016 mem_req_o SHALL be 1 only in REQ, so request-to-mem_req_o latency is 1 cycle; mem_* fields SHALL be the registered values and SHALL be stable while in REQ.
REQ-017 In REQ with mem_gnt_i=1, the owner's *_gnt_o SHALL pulse in that cycle and the next state SHALL be RSP; otherwise the FSM SHALL stay in REQ with no timeout.
REQ-018 In RSP with mem_rvalid_i=1, the owner's *_rvalid_o SHALL equal 1 combinationally and rdata_o SHALL equal mem_rdata_i; next state IDLE. Writes also complete on mem_rvalid_i.
REQ-019 mem_rvalid_i outside RSP SHALL be ignored and SHALL produce no *_rvalid_o.
REQ-020 A 16-bit timeout counter SHALL clear on entry to RSP and increment in each RSP cycle; when it reaches TIMEOUT_CYCLES without mem_rvalid_i, the owner's *_rvalid_o and *_err_o SHALL pulse together for 1 cycle (rdata_o=0) and the FSM SHALL go to IDLE.
REQ-021 If mem_rvalid_i arrives in the same cycle the timeout is reached, a normal completion SHALL take place (err=0).
REQ-022 The minimum transaction is IDLE->REQ->RSP->IDLE, 3 cycles; after a completion, the next arbitration SHALL happen in the following IDLE cycle.
REQ-023 Requesters SHALL hold *_req_i and their fields until *_gnt_o; a requester dropping req before it is selected SHALL be permitted and SHALL not be served.
REQ-024 busy_o SHALL be 1 in REQ and RSP.
REQ-025 conflict_cnt_o SHALL increment, saturating at 16'hFFFF, in each cycle in which a *_req_i is high and that requester is not the owner of a state outside IDLE, plus IDLE cycles in which the requester loses arbitration.
REQ-026 A non-owner SHALL never see gnt, rvalid or err.

Reset
REQ-027 While rst_i=1 at a clock edge: state IDLE, last owner fetch, registered fields 0, timeout and conflict counters 0; all outputs 0 in the following cycle.
REQ-028 Reset in REQ or RSP SHALL abandon the transaction with no gnt/rvalid to the requester; a late mem_rvalid_i SHALL be ignored under REQ-019.

Structure
REQ-029 The typedefs arb_state_e {IDLE, REQ, RSP} and arb_owner_e {OWN_IF, OWN_DM} SHALL go in riscv_pkg; TIMEOUT_CYCLES stays a module parameter.
REQ-030 The block SHALL be a single module with no sub-module, instantiated in the core between fetch/memory and the external memory port.

Verification
REQ-031 Fetch read of addr 0x100, mem_gnt_i 1 cycle after mem_req_o, rvalid 2 cycles later with 0xDEADBEEF -> if_gnt_o 1 pulse, if_rvalid_o with rdata_o=0xDEADBEEF, dm outputs 0.
REQ-032 Both requesting from reset, held 4 transactions -> owner order DM, IF, DM, IF; conflict_cnt_o nonzero and monotonic.
REQ-033 Data write addr 0x200, wdata 0x12345678, be 4'b0011, mem_gnt_i held low 5 cycles -> mem_req_o and fields stable for 5 cycles, then dm_gnt_o pulse.
REQ-034 TIMEOUT_CYCLES=4, no mem_rvalid_i -> dm_rvalid_o and dm_err_o pulse exactly 4 cycles after RSP entry, then IDLE; rvalid on the timeout cycle -> err=0.
REQ-035 rst_i asserted in RSP, then mem_rvalid_i -> no *_rvalid_o, busy_o=0, conflict_cnt_o=0.
